// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused over WIDTH cycles.
// Optional subtract mode with a `sub` port under `ifdef SERIAL_ADDER_SUB_EN.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;

    logic             ha0_s, ha0_c, cell_s, ha1_c, cell_c;
    logic [WIDTH-1:0] sum_shift;
    logic             last;
    logic             sub_en;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_en = sub;
`else
    assign sub_en = 1'b0;
`endif

    half_adder u_ha0 (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .s_o (ha0_s),
        .c_o (ha0_c)
    );

    half_adder u_ha1 (
        .a_i (ha0_s),
        .b_i (c_q),
        .s_o (cell_s),
        .c_o (ha1_c)
    );

    assign cell_c = ha0_c | ha1_c;

    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shift = cell_s;
        end else begin : g_wn
            assign sum_shift = {cell_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt_q == CW'(WIDTH - 1));

    // Next-state and datapath: load in IDLE, one bit per RUN cycle, pulse in DONE
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = sub_en ? ~b : b;
                    c_d     = sub_en;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                sum_d  = sum_shift;
                c_d    = cell_c;
                cnt_d  = cnt_q + 1'b1;
                if (last) begin
                    cout_d  = cell_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8).
// Subtract vectors run when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       carry_out;
    logic       busy;
    logic       done;

    int tests;
    int fails;

    logic [8:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got sum 0x%0h, expected no done",
                         sum);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({carry_out, sum} != e) begin
                    fails++;
                    $display("FAIL result: got {c,sum}=0x%0h, expected 0x%0h",
                             {carry_out, sum}, e);
                end
            end
        end
    end

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input logic [7:0] es,
                          input logic ec);
        int nb;
        bit seen;
        @(negedge clk);
        a = av;
        b = bv;
        sub = sv;
        start = 1'b1;
        exp_q.push_back({ec, es});
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        b = ~bv;
        nb = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
        check("done_seen", int'(seen), 1);
        check("busy_cycles", nb, 8);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("idle_after", int'(busy), 0);
        check("sum_held", int'(sum), int'(es));
        check("cout_held", int'(carry_out), int'(ec));
    endtask

    initial begin
        int nb;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        #12;
        check("rst_sum", int'(sum), 0);
        check("rst_cout", int'(carry_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

        // start pulses during RUN and DONE must be ignored
        @(negedge clk);
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        exp_q.push_back({1'b0, 8'h46});
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3 || k == 9) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'h77;
            end
            if (k == 9) check("mid_done", int'(done), 1);
        end
        @(negedge clk);
        start = 1'b0;
        check("no_relaunch", int'(busy), 0);
        nb = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy || done) nb++;
        end
        check("stay_idle", nb, 0);
        check("ignored_sum", int'(sum), 8'h46);

        // reset in the middle of RUN
        @(negedge clk);
        a = 8'hF0;
        b = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sum", int'(sum), 0);
        check("mid_rst_cout", int'(carry_out), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
        run_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
